// File: rtl/fir_sample_writer_if.sv
// Sample and coefficient stream handshakes into the FIR write-side controller.
// The source (master) drives valid/data; the writer (slave) drives ready.
interface fir_sample_writer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  c_valid;
    logic                  c_ready;
    logic [DATA_WIDTH-1:0] c_data;

    modport master (
        output s_valid, s_data, c_valid, c_data,
        input  s_ready, c_ready
    );

    modport slave (
        input  s_valid, s_data, c_valid, c_data,
        output s_ready, c_ready
    );
endinterface

// File: rtl/fir_sample_writer.sv
// Write-side controller for the FIR coefficient and circular sample memories.
// Define FIR_FILL_GATE_EN to hold off start until NTAPS samples are present.
module fir_sample_writer #(
    parameter int H_ADDR_WIDTH = 4,
    parameter int X_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fir_sample_writer_if.slave      bus,
    input  logic                    coef_reload,
    input  logic                    rd_done,
    output logic                    x_we,
    output logic [X_ADDR_WIDTH-1:0] x_waddr,
    output logic [DATA_WIDTH-1:0]   x_wdata,
    output logic                    h_we,
    output logic [H_ADDR_WIDTH-1:0] h_waddr,
    output logic [DATA_WIDTH-1:0]   h_wdata,
    output logic                    start,
    output logic [X_ADDR_WIDTH-1:0] x_base,
    output logic                    coef_loaded
);

    localparam int NTAPS = 1 << H_ADDR_WIDTH;

    typedef enum logic [1:0] {
        COEF,
        WAIT_SMP,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic [X_ADDR_WIDTH-1:0] wr_ptr;
    logic [H_ADDR_WIDTH-1:0] coef_cnt;
    logic c_fire;
    logic s_fire;
    logic reload;
    logic coef_last;
    logic issue_start;

    assign bus.c_ready = (state == COEF);
    assign bus.s_ready = (state == WAIT_SMP) && !coef_reload;
    assign c_fire      = bus.c_valid && bus.c_ready;
    assign s_fire      = bus.s_valid && bus.s_ready;
    assign reload      = (state == WAIT_SMP) && coef_reload;
    assign coef_last   = &coef_cnt;

`ifdef FIR_FILL_GATE_EN
    logic [H_ADDR_WIDTH:0] fill;

    // Fill survives coef reloads; only reset empties the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
        end else if (s_fire && fill != (H_ADDR_WIDTH+1)'(NTAPS)) begin
            fill <= fill + 1'b1;
        end
    end

    assign issue_start = (fill == (H_ADDR_WIDTH+1)'(NTAPS));
`else
    assign issue_start = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COEF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COEF: begin
                if (c_fire && coef_last) state_nxt = WAIT_SMP;
            end
            WAIT_SMP: begin
                if (reload)      state_nxt = COEF;
                else if (s_fire) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = issue_start ? WAIT_DONE : WAIT_SMP;
            end
            WAIT_DONE: begin
                if (rd_done) state_nxt = WAIT_SMP;
            end
            default: state_nxt = COEF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_we        <= 1'b0;
            x_waddr     <= '0;
            x_wdata     <= '0;
            h_we        <= 1'b0;
            h_waddr     <= '0;
            h_wdata     <= '0;
            start       <= 1'b0;
            x_base      <= '0;
            coef_loaded <= 1'b0;
            wr_ptr      <= '0;
            coef_cnt    <= '0;
        end else begin
            x_we  <= s_fire;
            h_we  <= c_fire;
            start <= (state == ISSUE) && issue_start;
            if (c_fire) begin
                h_waddr  <= coef_cnt;
                h_wdata  <= bus.c_data;
                coef_cnt <= coef_cnt + 1'b1;
                if (coef_last) coef_loaded <= 1'b1;
            end
            if (reload) begin
                coef_loaded <= 1'b0;
                coef_cnt    <= '0;
            end
            if (s_fire) begin
                x_waddr <= wr_ptr;
                x_wdata <= bus.s_data;
                x_base  <= wr_ptr;
                wr_ptr  <= wr_ptr + 1'b1;
            end
        end
    end

endmodule
